// File: rtl/atm_session_ctrl.sv
// ATM session controller: internal account table, request/response handshake,
// sequential table scan, per-account PIN lockout, session timeout and
// overflow-checked balance arithmetic.
module atm_session_ctrl #(
   parameter int NUM_ACC   = 16,
   parameter int ACC_W     = 12,
   parameter int PIN_W     = 4,
   parameter int BAL_W     = 16,
   parameter int INIT_BAL  = 500,
   parameter int TIMEOUT   = 100,
   parameter int MAX_TRIES = 3,
   localparam int IDX_W    = $clog2(NUM_ACC)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             prov_we,
   input  logic [IDX_W-1:0] prov_idx,
   input  logic [ACC_W-1:0] prov_acc,
   input  logic [PIN_W-1:0] prov_pin,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [ACC_W-1:0] req_acc,
   input  logic [PIN_W-1:0] req_pin,
   input  logic [ACC_W-1:0] req_dest,
   input  logic [BAL_W-1:0] req_amount,
   output logic             rsp_valid,
   output logic [2:0]       rsp_status,
   output logic [BAL_W-1:0] rsp_balance,
   output logic             session_act
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int FC_W  = $clog2(MAX_TRIES + 1);

   localparam logic [2:0] OP_LOGIN    = 3'd0;
   localparam logic [2:0] OP_BALANCE  = 3'd1;
   localparam logic [2:0] OP_WITHDRAW = 3'd2;
   localparam logic [2:0] OP_DEPOSIT  = 3'd3;
   localparam logic [2:0] OP_TRANSFER = 3'd4;
   localparam logic [2:0] OP_LOGOUT   = 3'd5;

   localparam logic [2:0] ST_OK       = 3'd0;
   localparam logic [2:0] ST_BAD_CRED = 3'd1;
   localparam logic [2:0] ST_LOCKED   = 3'd2;
   localparam logic [2:0] ST_INSUFF   = 3'd3;
   localparam logic [2:0] ST_NO_DEST  = 3'd4;
   localparam logic [2:0] ST_OVERFLOW = 3'd5;
   localparam logic [2:0] ST_NOT_AUTH = 3'd6;
   localparam logic [2:0] ST_TIMEOUT  = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE, S_SCAN, S_EXEC, S_RESP, S_SESSION
   } state_t;

   state_t state, state_nxt;

   // Account table
   logic [ACC_W-1:0] tab_acc   [NUM_ACC];
   logic [PIN_W-1:0] tab_pin   [NUM_ACC];
   logic [BAL_W-1:0] tab_bal   [NUM_ACC];
   logic [FC_W-1:0]  tab_fail  [NUM_ACC];
   logic             tab_valid [NUM_ACC];
   logic             tab_lock  [NUM_ACC];

   // Latched request and scan/session bookkeeping
   logic [2:0]       op_q;
   logic [ACC_W-1:0] acc_q;
   logic [PIN_W-1:0] pin_q;
   logic [ACC_W-1:0] dest_q;
   logic [BAL_W-1:0] amt_q;
   logic [IDX_W-1:0] scan_idx;
   logic [IDX_W-1:0] match_idx;
   logic             found;
   logic [IDX_W-1:0] sess_idx;
   logic [TMO_W-1:0] tmo_cnt;
   logic [2:0]       res_status;
   logic [BAL_W-1:0] res_bal;
   logic             res_sess;

   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both high; req_ready is high only in IDLE and SESSION.
   // Responses are single-cycle rsp_valid pulses with no backpressure.
   logic accept, prov_ok, tmo_hit;
   logic [ACC_W-1:0] scan_key;

   assign req_ready = (state == S_IDLE) || (state == S_SESSION);
   assign accept    = req_valid && req_ready;
   assign prov_ok   = prov_we && (state == S_IDLE) && !accept;
   assign tmo_hit   = (state == S_SESSION) && !accept && (tmo_cnt == TMO_W'(TIMEOUT - 1));
   assign scan_key  = (op_q == OP_LOGIN) ? acc_q : dest_q;

   // Execute-stage decision: status, resulting balance and table updates
   logic [2:0]       ex_status;
   logic [BAL_W-1:0] ex_bal;
   logic             ex_sess;
   logic             wr_own_en, wr_dst_en, login_ok, login_bad;
   logic [BAL_W-1:0] wr_own_val, wr_dst_val;
   logic [BAL_W-1:0] own_bal, dst_bal;
   logic [BAL_W:0]   own_sum, dst_sum;
   logic [FC_W-1:0]  fail_inc;

   assign own_bal  = tab_bal[sess_idx];
   assign dst_bal  = tab_bal[match_idx];
   assign own_sum  = {1'b0, own_bal} + {1'b0, amt_q};
   assign dst_sum  = {1'b0, dst_bal} + {1'b0, amt_q};
   assign fail_inc = tab_fail[match_idx] + FC_W'(1);

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (accept) state_nxt = (req_op == OP_LOGIN) ? S_SCAN : S_EXEC;
         S_SESSION: begin
            if (accept)       state_nxt = (req_op == OP_TRANSFER) ? S_SCAN : S_EXEC;
            else if (tmo_hit) state_nxt = S_IDLE;
         end
         S_SCAN:    if (scan_idx == IDX_W'(NUM_ACC - 1)) state_nxt = S_EXEC;
         S_EXEC:    state_nxt = S_RESP;
         S_RESP:    state_nxt = res_sess ? S_SESSION : S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Operation outcome evaluated while in EXEC
   always_comb begin
      ex_status  = ST_OK;
      ex_sess    = session_act;
      ex_bal     = session_act ? own_bal : '0;
      wr_own_en  = 1'b0;
      wr_own_val = own_bal;
      wr_dst_en  = 1'b0;
      wr_dst_val = dst_bal;
      login_ok   = 1'b0;
      login_bad  = 1'b0;
      if (op_q == OP_LOGIN) begin
         if (session_act)                   ex_status = ST_NOT_AUTH;
         else if (!found)                   ex_status = ST_BAD_CRED;
         else if (tab_lock[match_idx])      ex_status = ST_LOCKED;
         else if (pin_q != tab_pin[match_idx]) begin
            ex_status = ST_BAD_CRED;
            login_bad = 1'b1;
         end else begin
            login_ok = 1'b1;
            ex_sess  = 1'b1;
            ex_bal   = dst_bal;
         end
      end else if (!session_act || op_q > OP_LOGOUT) begin
         ex_status = ST_NOT_AUTH;
      end else begin
         case (op_q)
            OP_WITHDRAW: begin
               if (amt_q > own_bal) ex_status = ST_INSUFF;
               else begin
                  wr_own_en  = 1'b1;
                  wr_own_val = own_bal - amt_q;
                  ex_bal     = wr_own_val;
               end
            end
            OP_DEPOSIT: begin
               if (own_sum[BAL_W]) ex_status = ST_OVERFLOW;
               else begin
                  wr_own_en  = 1'b1;
                  wr_own_val = own_sum[BAL_W-1:0];
                  ex_bal     = wr_own_val;
               end
            end
            OP_TRANSFER: begin
               if (!found)                    ex_status = ST_NO_DEST;
               else if (amt_q > own_bal)      ex_status = ST_INSUFF;
               else if (dst_sum[BAL_W])       ex_status = ST_OVERFLOW;
               else if (match_idx != sess_idx) begin
                  wr_own_en  = 1'b1;
                  wr_own_val = own_bal - amt_q;
                  wr_dst_en  = 1'b1;
                  wr_dst_val = dst_sum[BAL_W-1:0];
                  ex_bal     = wr_own_val;
               end
            end
            OP_LOGOUT: begin
               ex_sess = 1'b0;
               ex_bal  = '0;
            end
            default: ;  // BALANCE: report current balance
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Request capture and sequential account scan (lowest matching slot wins)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q      <= '0;
         acc_q     <= '0;
         pin_q     <= '0;
         dest_q    <= '0;
         amt_q     <= '0;
         scan_idx  <= '0;
         match_idx <= '0;
         found     <= 1'b0;
      end else if (accept) begin
         op_q      <= req_op;
         acc_q     <= req_acc;
         pin_q     <= req_pin;
         dest_q    <= req_dest;
         amt_q     <= req_amount;
         scan_idx  <= '0;
         match_idx <= '0;
         found     <= 1'b0;
      end else if (state == S_SCAN) begin
         scan_idx <= scan_idx + IDX_W'(1);
         if (!found && tab_valid[scan_idx] && tab_acc[scan_idx] == scan_key) begin
            found     <= 1'b1;
            match_idx <= scan_idx;
         end
      end
   end

   // Account table: provisioning writes and EXEC-stage updates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ACC; i++) begin
            tab_acc[i]   <= '0;
            tab_pin[i]   <= '0;
            tab_bal[i]   <= '0;
            tab_fail[i]  <= '0;
            tab_valid[i] <= 1'b0;
            tab_lock[i]  <= 1'b0;
         end
      end else begin
         if (prov_ok) begin
            tab_acc[prov_idx]   <= prov_acc;
            tab_pin[prov_idx]   <= prov_pin;
            tab_bal[prov_idx]   <= BAL_W'(INIT_BAL);
            tab_fail[prov_idx]  <= '0;
            tab_valid[prov_idx] <= 1'b1;
            tab_lock[prov_idx]  <= 1'b0;
         end
         if (state == S_EXEC) begin
            if (wr_own_en) tab_bal[sess_idx]  <= wr_own_val;
            if (wr_dst_en) tab_bal[match_idx] <= wr_dst_val;
            if (login_ok)  tab_fail[match_idx] <= '0;
            if (login_bad) begin
               tab_fail[match_idx] <= fail_inc;
               if (fail_inc >= FC_W'(MAX_TRIES)) tab_lock[match_idx] <= 1'b1;
            end
         end
      end
   end

   // Session slot, idle timer and pending result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sess_idx   <= '0;
         tmo_cnt    <= '0;
         res_status <= '0;
         res_bal    <= '0;
         res_sess   <= 1'b0;
      end else begin
         if (state != S_SESSION || accept) tmo_cnt <= '0;
         else                              tmo_cnt <= tmo_cnt + TMO_W'(1);
         if (state == S_EXEC) begin
            res_status <= ex_status;
            res_bal    <= ex_bal;
            res_sess   <= ex_sess;
            if (login_ok) sess_idx <= match_idx;
         end
      end
   end

   // Response pulse and held status/balance/session outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid   <= 1'b0;
         rsp_status  <= '0;
         rsp_balance <= '0;
         session_act <= 1'b0;
      end else if (state == S_RESP) begin
         rsp_valid   <= 1'b1;
         rsp_status  <= res_status;
         rsp_balance <= res_bal;
         session_act <= res_sess;
      end else if (tmo_hit) begin
         rsp_valid   <= 1'b1;
         rsp_status  <= ST_TIMEOUT;
         rsp_balance <= '0;
         session_act <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
      end
   end

endmodule
